// File: rtl/vending_pkg.sv
// Shared definitions for the vending session arbiter: FSM state encoding
// and the default sizing used when the top is instantiated without overrides.
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_SERVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam int N_KIOSK_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 200;

endpackage

// File: rtl/vending_session_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin picker. Scans the request vector
// upward starting at ptr_i, wrapping from N-1 back to 0, and returns the first
// requester as a one-hot vector and as an index. Also used by the printer arbiter.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   onehot_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // First set request at or after the pointer wins; later hits are ignored.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int off = 0; off < N; off++) begin
      int             kk;
      logic [IDW-1:0] k;
      kk = int'(ptr_i) + off;
      if (kk >= N) kk = kk - N;
      k = IDW'(kk);
      if (!any_o && req_i[k]) begin
        any_o       = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o       = k;
      end
    end
  end

endmodule

// File: rtl/vending_session_arbiter.sv
// vending_session_arbiter: hands the shared vending_machine core to one kiosk
// per ticket session, clears the core between sessions, aborts idle sessions
// and rotates priority round-robin.
// Optional build macro VSA_STAFF_PRIORITY_EN: kiosk 0 (staff console) wins
// every arbitration it takes part in and does not advance the rotation pointer.
module vending_session_arbiter
  import vending_pkg::*;
#(
  parameter int N_KIOSK     = N_KIOSK_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 8,
  parameter int ID_W        = $clog2(N_KIOSK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_KIOSK-1:0] req,
  input  logic [N_KIOSK-1:0] done,
  input  logic [N_KIOSK-1:0] activity,
  output logic [N_KIOSK-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               vm_reset,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [N_KIOSK-1:0]   gnt_q, gnt_d;
  logic [N_KIOSK-1:0]   sel_q, sel_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 busy_q, busy_d;
  logic                 vm_reset_q, vm_reset_d;
  logic                 timeout_q, timeout_d;

  logic [N_KIOSK-1:0]   pick_oh, win_oh;
  logic [ID_W-1:0]      pick_idx, win_idx, ptr_next;
  logic                 pick_any;
  logic                 sel_done, sel_req, sel_act;

  rr_pick #(
    .N   (N_KIOSK),
    .IDW (ID_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Events are only honoured from the kiosk that owns the session.
  assign sel_done = |(done & sel_q);
  assign sel_req  = |(req & sel_q);
  assign sel_act  = |(activity & sel_q);
  assign ptr_next = (gnt_id_q == ID_W'(N_KIOSK - 1)) ? '0 : gnt_id_q + 1'b1;

  // Final winner: round-robin pick, optionally overridden by the staff console.
  always_comb begin
    win_oh  = pick_oh;
    win_idx = pick_idx;
`ifdef VSA_STAFF_PRIORITY_EN
    if (req[0]) begin
      win_oh    = '0;
      win_oh[0] = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Session FSM: next state and next value of every registered output.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    sel_d      = sel_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    busy_d     = 1'b0;
    vm_reset_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d    = S_CLEAR;
          sel_d      = win_oh;
          gnt_id_d   = win_idx;
          busy_d     = 1'b1;
          vm_reset_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d    = S_SERVE;
        gnt_d      = sel_q;
        busy_d     = 1'b1;
        idle_cnt_d = '0;
      end
      S_SERVE: begin
        busy_d = 1'b1;
        if (sel_done || !sel_req) begin
          state_d = S_RELEASE;
        end else if (!sel_act && idle_cnt_q == IDLE_LIMIT) begin
          state_d   = S_RELEASE;
          timeout_d = 1'b1;
        end else begin
          gnt_d      = sel_q;
          idle_cnt_d = sel_act ? '0 : idle_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
`ifdef VSA_STAFF_PRIORITY_EN
        if (gnt_id_q != '0) rr_ptr_d = ptr_next;
`else
        rr_ptr_d = ptr_next;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      busy_q     <= 1'b0;
      vm_reset_q <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      busy_q     <= busy_d;
      vm_reset_q <= vm_reset_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign vm_reset = vm_reset_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_vending_session_arbiter.sv
// Self-checking bench for vending_session_arbiter (N_KIOSK=4, TIMEOUT_CYC=8).
// Expected grant owners are queued when requests are driven and popped when
// a grant appears; cycle-exact latencies are checked inline.
module tb_vending_session_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] activity;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       vm_reset;
  logic       timeout;

  int checkCount = 0;
  int errorCount = 0;
  int expQ[$];
  logic [3:0] prevGnt = '0;

  vending_session_arbiter #(
    .N_KIOSK     (4),
    .TIMEOUT_CYC (8),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .activity (activity),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .vm_reset (vm_reset),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive inputs, then let one rising edge pass and return on the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a);
    req      = r;
    done     = d;
    activity = a;
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant to show up while keeping inputs steady.
  task automatic waitGrant(input logic [3:0] r);
    int cnt;
    cnt = 0;
    while (gnt == 4'b0000 && cnt < 10) begin
      applyStimulus(r, 4'b0000, 4'b0000);
      cnt++;
    end
    checkOutput("grantWait", {31'b0, (gnt != 4'b0000)}, 32'd1);
  endtask

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("multiHot", {31'b0, ($countones(gnt) > 1)}, 32'd0);
      checkOutput("gntWithVmReset", {31'b0, (|gnt && vm_reset)}, 32'd0);
    end
    if (gnt != 4'b0000 && prevGnt == 4'b0000) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnderflow", expQ.size(), 32'd1);
      end else begin
        int e;
        e = expQ.pop_front();
        checkOutput("grantId", {30'b0, gnt_id}, e);
        checkOutput("grantOneHot", {28'b0, gnt}, 32'd1 << e);
      end
    end
    prevGnt = gnt;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[4];
    order = '{0, 1, 3, 0};
    reset = 1'b1;
    req = '0; done = '0; activity = '0;
    @(negedge clk);
    checkOutput("rstGnt", {28'b0, gnt}, 32'd0);
    checkOutput("rstGntId", {30'b0, gnt_id}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstVmReset", {31'b0, vm_reset}, 32'd1);
    checkOutput("rstTimeout", {31'b0, timeout}, 32'd0);
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("idleVmReset", {31'b0, vm_reset}, 32'd0);

    $display("[TB] single kiosk latency");
    expQ.push_back(2);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    checkOutput("clrBusy", {31'b0, busy}, 32'd1);
    checkOutput("clrVmReset", {31'b0, vm_reset}, 32'd1);
    checkOutput("clrGnt", {28'b0, gnt}, 32'd0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    checkOutput("srvGnt", {28'b0, gnt}, 32'h4);
    checkOutput("srvVmReset", {31'b0, vm_reset}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    checkOutput("doneGntDrop", {28'b0, gnt}, 32'd0);
    checkOutput("doneBusyHeld", {31'b0, busy}, 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("doneBusyDrop", {31'b0, busy}, 32'd0);

    $display("[TB] contention round-robin");
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) expQ.push_back(order[s]);
    for (int s = 0; s < 4; s++) begin
      waitGrant(4'b1011);
      for (int i = 0; i < 4; i++) applyStimulus(4'b1011, 4'b0000, 4'b0000);
      applyStimulus((s == 3) ? 4'b0000 : 4'b1011, 4'b0001 << order[s], 4'b0000);
      checkOutput("rrGntDrop", {28'b0, gnt}, 32'd0);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] inactivity timeout");
    expQ.push_back(1);
    applyStimulus(4'b0010, 4'b0000, 4'b0001);
    applyStimulus(4'b0010, 4'b0000, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0010, 4'b0000, 4'b0001);
      checkOutput("toEarly", {31'b0, timeout}, 32'd0);
      checkOutput("toGntHeld", {28'b0, gnt}, 32'h2);
    end
    applyStimulus(4'b0010, 4'b0000, 4'b0001);
    checkOutput("toPulse", {31'b0, timeout}, 32'd1);
    checkOutput("toGntDrop", {28'b0, gnt}, 32'd0);
    checkOutput("toBusy", {31'b0, busy}, 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("toPulseOnce", {31'b0, timeout}, 32'd0);
    checkOutput("toBusyDrop", {31'b0, busy}, 32'd0);

    $display("[TB] done coincides with timeout");
    expQ.push_back(1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 7; i++) applyStimulus(4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0010, 4'b0000);
    checkOutput("doneWinsGnt", {28'b0, gnt}, 32'd0);
    checkOutput("doneWinsTimeout", {31'b0, timeout}, 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] periodic activity keeps session alive");
    expQ.push_back(1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(4'b0010, (i == 23) ? 4'b1000 : 4'b0000, (i % 5 == 0) ? 4'b0010 : 4'b0000);
      checkOutput("actNoTimeout", {31'b0, timeout}, 32'd0);
      checkOutput("actGntHeld", {28'b0, gnt}, 32'h2);
    end
    applyStimulus(4'b0010, 4'b0010, 4'b0000);
    checkOutput("actDoneDrop", {28'b0, gnt}, 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] withdraw");
    expQ.push_back(3);
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("wdGntDrop", {28'b0, gnt}, 32'd0);
    checkOutput("wdBusy", {31'b0, busy}, 32'd1);
    checkOutput("wdNoTimeout", {31'b0, timeout}, 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("wdBusyDrop", {31'b0, busy}, 32'd0);
    checkOutput("wdNoTimeout2", {31'b0, timeout}, 32'd0);
    expQ.push_back(0);
    waitGrant(4'b1001);
    applyStimulus(4'b1001, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0001, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] reset mid-session");
    expQ.push_back(2);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    checkOutput("midRstGnt", {28'b0, gnt}, 32'd0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    checkOutput("midRstVmReset", {31'b0, vm_reset}, 32'd1);
    checkOutput("midRstTimeout", {31'b0, timeout}, 32'd0);
    checkOutput("midRstGntId", {30'b0, gnt_id}, 32'd0);
    expQ.push_back(1);
    waitGrant(4'b0010);
    checkOutput("postRstGntId", {30'b0, gnt_id}, 32'd1);
    applyStimulus(4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    checkOutput("sbLeftover", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
